// File: rtl/nibble_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : nibble_add_seq
// Brief    : Wide add/subtract sequenced one nibble at a time through a
//            shared external 4-bit ripple adder slice.
// Revision : 1.0
// ============================================================================
module nibble_add_seq #(
    parameter int NIBBLES = 4,
    parameter int SETTLE  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sub,
    input  logic                 c_in,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_s,
    input  logic                 add_cout,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 c_out,
    output logic                 ovf
);

    localparam int c_w     = 4 * NIBBLES;
    localparam int c_idx_w = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int c_cnt_w = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NIBBLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SETTLE - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_idx_w-1:0] r_idx;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_carry;
    logic [c_w-1:0]     r_a;
    logic [c_w-1:0]     r_b;
    logic [c_w-1:0]     r_sum;
    logic               r_c_out;
    logic               r_ovf;

    logic               w_accept;
    logic               w_in_wait;
    logic               w_capture;
    logic               w_last_idx;
    logic [3:0]         w_a_nib;
    logic [3:0]         w_b_nib;

    assign w_in_wait  = (r_state == c_st_wait);
    assign w_accept   = start && ((r_state == c_st_idle) || (r_state == c_st_done));
    assign w_capture  = w_in_wait && (r_cnt == c_cnt_last);
    assign w_last_idx = (r_idx == c_idx_last);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (start) w_state_nxt = c_st_wait;
            c_st_wait: if (w_capture && w_last_idx) w_state_nxt = c_st_done;
            c_st_done: w_state_nxt = start ? c_st_wait : c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------- nibble select
    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (r_idx == i[c_idx_w-1:0]) begin
                w_a_nib = r_a[4*i +: 4];
                w_b_nib = r_b[4*i +: 4];
            end
        end
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Subtract is a + ~b + 1, so the inversion and the +1 are folded in here.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub | c_in;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_sum   <= '0;
        end else if (w_in_wait) begin
            if (!w_capture) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (r_idx == i[c_idx_w-1:0]) begin
                        r_sum[4*i +: 4] <= add_s;
                    end
                end
                r_carry <= add_cout;
                r_cnt   <= '0;
                if (w_last_idx) begin
                    r_c_out <= add_cout;
                    r_ovf   <= (r_a[c_w-1] == r_b[c_w-1]) && (add_s[3] != r_a[c_w-1]);
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign add_a   = w_in_wait ? w_a_nib : 4'h0;
    assign add_b   = w_in_wait ? w_b_nib : 4'h0;
    assign add_cin = w_in_wait & r_carry;
    assign busy    = w_in_wait;
    assign done    = (r_state == c_st_done);
    assign sum     = r_sum;
    assign c_out   = r_c_out;
    assign ovf     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_nibble_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_add_seq
// Brief    : Directed bench for nibble_add_seq at SETTLE=1 and SETTLE=3.
// Revision : 1.0
// ============================================================================
module tb_nibble_add_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start1, start3, sub, c_in;
    logic [15:0] a, b;

    logic [3:0]  add_a1, add_b1, add_s1, add_a3, add_b3, add_s3;
    logic        add_cin1, add_cout1, add_cin3, add_cout3;
    logic        busy1, done1, c_out1, ovf1, busy3, done3, c_out3, ovf3;
    logic [15:0] sum1, sum3;

    int checks = 0;
    int errors = 0;

    logic [4:0]  trace [0:63];
    logic [3:0]  first_b;
    logic        first_cin;

    always #5 clk = ~clk;

    nibble_add_seq #(.NIBBLES(4), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub), .c_in(c_in),
        .a(a), .b(b), .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
        .add_s(add_s1), .add_cout(add_cout1), .busy(busy1), .done(done1),
        .sum(sum1), .c_out(c_out1), .ovf(ovf1)
    );

    nibble_add_seq #(.NIBBLES(4), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .sub(sub), .c_in(c_in),
        .a(a), .b(b), .add_a(add_a3), .add_b(add_b3), .add_cin(add_cin3),
        .add_s(add_s3), .add_cout(add_cout3), .busy(busy3), .done(done3),
        .sum(sum3), .c_out(c_out3), .ovf(ovf3)
    );

    // Slice models: ideal adder for SETTLE=1, two-cycle-late adder for SETTLE=3.
    assign {add_cout1, add_s1} = {1'b0, add_a1} + {1'b0, add_b1} + {4'b0, add_cin1};

    logic [4:0] w_f3, r_p1, r_p2;
    assign w_f3 = {1'b0, add_a3} + {1'b0, add_b3} + {4'b0, add_cin3};
    always @(posedge clk) begin
        r_p1 <= w_f3;
        r_p2 <= r_p1;
    end
    assign {add_cout3, add_s3} = r_p2;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic launch(input bit sel, input logic [15:0] va, input logic [15:0] vb,
                          input logic vs, input logic vc);
        @(negedge clk);
        a = va; b = vb; sub = vs; c_in = vc;
        if (sel) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    // Called just after the accept edge; lat counts edges until done is seen.
    task automatic wait_done(input bit sel, output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (1) begin
            if (lat < 64) trace[lat] = sel ? {add_a3, add_cin3} : {add_a1, add_cin1};
            if (lat == 0) begin
                first_b   = sel ? add_b3 : add_b1;
                first_cin = sel ? add_cin3 : add_cin1;
            end
            if (sel ? busy3 : busy1) bc++;
            if (sel ? done3 : done1) break;
            if (lat >= 200) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: got no done expected done within 200 cycles");
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got hang expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc;
        logic [15:0] opa;
        logic [3:0]  nib;
        logic [3:0]  cin_exp;

        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

        rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; sub = 1'b0; c_in = 1'b0;
        a = '0; b = '0;
        #23;
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_sum", sum1, 0);
        check("rst_cout_ovf", {c_out1, ovf1}, 0);
        check("rst_add", {add_a1, add_b1, add_cin1}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            launch(1'b0, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
            wait_done(1'b0, lat, bc);
            check($sformatf("v%0d_sum", i), sum1, vecs[i].s);
            check($sformatf("v%0d_cout", i), c_out1, vecs[i].co);
            check($sformatf("v%0d_ovf", i), ovf1, vecs[i].ov);
            check($sformatf("v%0d_lat", i), lat, 4);
            check($sformatf("v%0d_busy", i), bc, 4);
            if (i == 3) begin
                check("sub_first_b", first_b, 4'h8);
                check("sub_first_cin", first_cin, 1);
            end
            @(posedge clk); #1;
            @(posedge clk); #1;
            check($sformatf("v%0d_hold_sum", i), sum1, vecs[i].s);
            check($sformatf("v%0d_done_pulse", i), done1, 0);
        end

        // SETTLE=3: each nibble held three cycles on the slice.
        launch(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0);
        wait_done(1'b1, lat, bc);
        check("s3_lat", lat, 12);
        check("s3_busy", bc, 12);
        check("s3_sum", sum3, 16'h0100);
        check("s3_cout_ovf", {c_out3, ovf3}, 0);
        opa     = 16'h00FF;
        cin_exp = 4'b0110;
        for (int k = 0; k < 12; k++) begin
            nib = opa[4*(k/3) +: 4];
            check($sformatf("s3_trace%0d", k), trace[k], {nib, cin_exp[k/3]});
        end

        // start during WAIT is ignored.
        launch(1'b0, 16'h0001, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        a = 16'h1111; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        wait_done(1'b0, lat, bc);
        check("ign_lat", lat, 3);
        check("ign_sum", sum1, 16'h0002);

        // Back-to-back accept in the DONE cycle.
        @(negedge clk);
        a = 16'h0003; b = 16'h0004; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        check("b2b_busy", busy1, 1);
        check("b2b_done", done1, 0);
        wait_done(1'b0, lat, bc);
        check("b2b_lat", lat, 4);
        check("b2b_sum", sum1, 16'h0007);

        // Asynchronous reset mid-operation at idx=2.
        @(posedge clk); #1;
        launch(1'b0, 16'h1234, 16'h1111, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_partial", sum1, 16'h0045);
        check("pre_rst_add_a", add_a1, 4'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy_done", {busy1, done1}, 0);
        check("arst_sum", sum1, 0);
        check("arst_cout_ovf", {c_out1, ovf1}, 0);
        check("arst_add", {add_a1, add_b1, add_cin1}, 0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check($sformatf("arst_nodone%0d", k), done1, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        launch(1'b0, 16'h0F0F, 16'h0101, 1'b0, 1'b0);
        wait_done(1'b0, lat, bc);
        check("post_rst_lat", lat, 4);
        check("post_rst_sum", sum1, 16'h1010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
